// File: rtl/count_bcd_display.sv
// count_bcd_display
//   Reader side of the 13-bit up-counter. Samples a binary count, converts it to
//   packed BCD with an iterative shift-add-3 (double-dabble) engine, and drives
//   four active-low seven-segment digits from the registered result.
//
// Parameters
//   WIDTH          binary input width; 10**DIGITS must exceed 2**WIDTH-1
//   DIGITS         BCD digits produced (hex0..hex3 show the low four digits,
//                  so DIGITS must be at least 4)
//   BLANK_LEADING  1 = blank leading-zero digits above digit 0, 0 = show all
//
// Ports
//   clk       in   system clock, all state on rising edge
//   resetn    in   asynchronous active-low reset
//   count_in  in   binary value to convert
//   load      in   conversion request, honoured only while idle
//   auto_en   in   self-trigger whenever count_in differs from the last value
//   busy      out  high while a conversion is shifting or completing
//   valid     out  one-cycle pulse when bcd/hex have just been updated
//   bcd       out  last completed result, digit 0 in [3:0]
//   hex0..3   out  segments {g,f,e,d,c,b,a}, active-low

module count_bcd_display #(
  parameter int WIDTH         = 13,
  parameter int DIGITS        = 4,
  parameter int BLANK_LEADING = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [WIDTH-1:0]      count_in,
  input  logic                  load,
  input  logic                  auto_en,
  output logic                  busy,
  output logic                  valid,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [6:0]            hex0,
  output logic [6:0]            hex1,
  output logic [6:0]            hex2,
  output logic [6:0]            hex3
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state;
  logic [WIDTH-1:0]    sreg;
  logic [WIDTH-1:0]    last;
  logic [4*DIGITS-1:0] scratch;
  logic [4*DIGITS-1:0] adjusted;
  logic [CW-1:0]       cnt;
  logic                trigger;

  // A conversion starts on an explicit load, or automatically when the input
  // has moved away from the value most recently captured.
  assign trigger = load | (auto_en & (count_in != last));

  // Double-dabble correction: any digit that would reach 10 or more after
  // doubling is pre-biased by 3 so the carry lands in the next digit.
  always_comb begin
    adjusted = scratch;
    for (int d = 0; d < DIGITS; d++) begin
      if (scratch[4*d +: 4] >= 4'd5) begin
        adjusted[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
      end
    end
  end

  // Conversion sequencer. The input is captured once at trigger so later
  // changes on count_in cannot corrupt a conversion already in flight;
  // requests arriving while busy are dropped rather than queued.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      sreg    <= '0;
      last    <= '0;
      scratch <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      valid   <= 1'b0;
      bcd     <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (trigger) begin
            sreg    <= count_in;
            last    <= count_in;
            scratch <= '0;
            cnt     <= CW'(WIDTH);
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          // The MSB of the binary operand feeds into the LSB of the BCD scratch.
          {scratch, sreg} <= {adjusted[4*DIGITS-2:0], sreg, 1'b0};
          cnt             <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          bcd   <= scratch;
          valid <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Active-low segment pattern {g,f,e,d,c,b,a}; non-decimal nibbles go blank.
  function automatic logic [6:0] seg7(input logic [3:0] digit);
    logic [6:0] segs;
    case (digit)
      4'd0:    segs = 7'b1000000;
      4'd1:    segs = 7'b1111001;
      4'd2:    segs = 7'b0100100;
      4'd3:    segs = 7'b0110000;
      4'd4:    segs = 7'b0011001;
      4'd5:    segs = 7'b0010010;
      4'd6:    segs = 7'b0000010;
      4'd7:    segs = 7'b1111000;
      4'd8:    segs = 7'b0000000;
      4'd9:    segs = 7'b0010000;
      default: segs = 7'b1111111;
    endcase
    return segs;
  endfunction

  logic [6:0] digitSegs [DIGITS];
  logic       upperZero;

  // Walk from the most significant digit down, tracking whether every digit
  // at or above the current one is zero. Digit 0 always shows, so a zero
  // count still reads "0".
  always_comb begin
    upperZero = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      digitSegs[k] = 7'b1111111;
    end
    for (int k = DIGITS - 1; k >= 0; k--) begin
      upperZero = upperZero & (bcd[4*k +: 4] == 4'd0);
      if ((BLANK_LEADING != 0) && (k > 0) && upperZero) begin
        digitSegs[k] = 7'b1111111;
      end else begin
        digitSegs[k] = seg7(bcd[4*k +: 4]);
      end
    end
  end

  assign hex0 = digitSegs[0];
  assign hex1 = digitSegs[1];
  assign hex2 = digitSegs[2];
  assign hex3 = digitSegs[3];

endmodule

// File: tb/tb_count_bcd_display.sv
// tb_count_bcd_display
//   Directed bench for count_bcd_display. Two instances share all inputs:
//   dut blanks leading zeros, dutNb shows every digit. Expected values are
//   hand-computed decimal renderings of the applied counts.

module tb_count_bcd_display;

  logic        clk;
  logic        resetn;
  logic [12:0] count_in;
  logic        load;
  logic        auto_en;

  logic        busy,  busyNb;
  logic        valid, validNb;
  logic [15:0] bcd,   bcdNb;
  logic [6:0]  hex0, hex1, hex2, hex3;
  logic [6:0]  nb0, nb1, nb2, nb3;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  int vectors     = 0;
  int miscompares = 0;
  int validCount;
  int busyCount;
  int firstValidAt;
  logic [15:0] seenBcd [$];

  count_bcd_display #(.WIDTH(13), .DIGITS(4), .BLANK_LEADING(1)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .count_in (count_in),
    .load     (load),
    .auto_en  (auto_en),
    .busy     (busy),
    .valid    (valid),
    .bcd      (bcd),
    .hex0     (hex0),
    .hex1     (hex1),
    .hex2     (hex2),
    .hex3     (hex3)
  );

  count_bcd_display #(.WIDTH(13), .DIGITS(4), .BLANK_LEADING(0)) dutNb (
    .clk      (clk),
    .resetn   (resetn),
    .count_in (count_in),
    .load     (load),
    .auto_en  (auto_en),
    .busy     (busyNb),
    .valid    (validNb),
    .bcd      (bcdNb),
    .hex0     (nb0),
    .hex1     (nb1),
    .hex2     (nb2),
    .hex3     (nb3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Pulse load for one edge with the given value.
  task automatic applyStimulus(input logic [12:0] value);
    count_in = value;
    load     = 1'b1;
    tick();
    load     = 1'b0;
  endtask

  // Observe n cycles, tallying busy/valid and recording bcd at each pulse.
  task automatic runWindow(input int n);
    validCount   = 0;
    busyCount    = 0;
    firstValidAt = -1;
    seenBcd.delete();
    for (int i = 0; i < n; i++) begin
      if (busy) busyCount++;
      if (valid) begin
        validCount++;
        if (firstValidAt < 0) firstValidAt = i;
        seenBcd.push_back(bcd);
      end
      tick();
    end
  endtask

  initial begin
    resetn   = 1'b0;
    count_in = '0;
    load     = 1'b0;
    auto_en  = 1'b0;
    repeat (3) tick();

    $display("[TB] reset state");
    checkOutput("reset busy",  32'(busy),  32'd0);
    checkOutput("reset valid", 32'(valid), 32'd0);
    checkOutput("reset bcd",   32'(bcd),   32'h0000);
    checkOutput("reset hex0",  32'(hex0),  32'(SEG_0));
    checkOutput("reset hex1",  32'(hex1),  32'(SEG_BLANK));
    checkOutput("reset hex3",  32'(hex3),  32'(SEG_BLANK));
    checkOutput("reset nb hex3", 32'(nb3), 32'(SEG_0));
    resetn = 1'b1;
    tick();

    $display("[TB] full-scale 8191");
    applyStimulus(13'd8191);
    runWindow(30);
    checkOutput("8191 busy cycles", 32'(busyCount),    32'd14);
    checkOutput("8191 valid pulses", 32'(validCount),  32'd1);
    checkOutput("8191 latency",      32'(firstValidAt), 32'd14);
    checkOutput("8191 bcd",  32'(bcd),  32'h8191);
    checkOutput("8191 hex3", 32'(hex3), 32'(SEG_8));
    checkOutput("8191 hex2", 32'(hex2), 32'(SEG_1));
    checkOutput("8191 hex1", 32'(hex1), 32'(SEG_9));
    checkOutput("8191 hex0", 32'(hex0), 32'(SEG_1));

    $display("[TB] zero with and without blanking");
    applyStimulus(13'd0);
    runWindow(20);
    checkOutput("zero valid pulses", 32'(validCount), 32'd1);
    checkOutput("zero bcd",  32'(bcd),  32'h0000);
    checkOutput("zero hex0", 32'(hex0), 32'(SEG_0));
    checkOutput("zero hex1", 32'(hex1), 32'(SEG_BLANK));
    checkOutput("zero hex2", 32'(hex2), 32'(SEG_BLANK));
    checkOutput("zero hex3", 32'(hex3), 32'(SEG_BLANK));
    checkOutput("zero nb hex0", 32'(nb0), 32'(SEG_0));
    checkOutput("zero nb hex1", 32'(nb1), 32'(SEG_0));
    checkOutput("zero nb hex2", 32'(nb2), 32'(SEG_0));
    checkOutput("zero nb hex3", 32'(nb3), 32'(SEG_0));

    $display("[TB] load while busy is ignored");
    applyStimulus(13'd42);
    validCount = 0;
    for (int i = 0; i < 30; i++) begin
      count_in = 13'd77;
      load     = busy;
      if (valid) validCount++;
      tick();
    end
    load = 1'b0;
    checkOutput("busy-load valid pulses", 32'(validCount), 32'd1);
    checkOutput("busy-load bcd",  32'(bcd),  32'h0042);
    checkOutput("42 hex1", 32'(hex1), 32'(SEG_4));
    checkOutput("42 hex0", 32'(hex0), 32'(SEG_2));
    checkOutput("42 hex2", 32'(hex2), 32'(SEG_BLANK));
    applyStimulus(13'd77);
    runWindow(20);
    checkOutput("77 bcd", 32'(bcd), 32'h0077);

    $display("[TB] reset mid-conversion");
    applyStimulus(13'd1234);
    repeat (6) tick();
    resetn = 1'b0;
    #1;
    checkOutput("abort busy",  32'(busy),  32'd0);
    checkOutput("abort valid", 32'(valid), 32'd0);
    checkOutput("abort bcd",   32'(bcd),   32'h0000);
    checkOutput("abort hex0",  32'(hex0),  32'(SEG_0));
    repeat (2) tick();
    resetn = 1'b1;
    runWindow(20);
    checkOutput("abort no valid", 32'(validCount), 32'd0);
    checkOutput("abort no busy",  32'(busyCount),  32'd0);
    applyStimulus(13'd1234);
    runWindow(20);
    checkOutput("1234 bcd",  32'(bcd),  32'h1234);
    checkOutput("1234 hex3", 32'(hex3), 32'(SEG_1));
    checkOutput("1234 hex2", 32'(hex2), 32'(SEG_2));
    checkOutput("1234 hex1", 32'(hex1), 32'(SEG_3));
    checkOutput("1234 hex0", 32'(hex0), 32'(SEG_4));

    $display("[TB] auto trigger on change");
    count_in = 13'd9;
    auto_en  = 1'b1;
    runWindow(20);
    checkOutput("auto 9 pulses", 32'(validCount), 32'd1);
    checkOutput("auto 9 bcd", 32'(bcd), 32'h0009);
    count_in = 13'd10;
    runWindow(20);
    checkOutput("auto 10 pulses", 32'(validCount), 32'd1);
    checkOutput("auto 10 bcd", 32'(bcd), 32'h0010);
    checkOutput("10 hex1", 32'(hex1), 32'(SEG_1));
    checkOutput("10 hex0", 32'(hex0), 32'(SEG_0));
    runWindow(20);
    checkOutput("auto 10 repeat pulses", 32'(validCount), 32'd0);
    count_in = 13'd11;
    runWindow(20);
    checkOutput("auto 11 pulses", 32'(validCount), 32'd1);
    checkOutput("auto 11 bcd", 32'(bcd), 32'h0011);

    $display("[TB] input change during shift");
    count_in = 13'd8190;
    tick();
    validCount = 0;
    seenBcd.delete();
    for (int i = 0; i < 50; i++) begin
      if (i == 2) count_in = 13'd8191;
      if (valid) begin
        validCount++;
        seenBcd.push_back(bcd);
      end
      tick();
    end
    auto_en = 1'b0;
    checkOutput("reconvert pulses", 32'(validCount), 32'd2);
    checkOutput("reconvert first",
                (seenBcd.size() > 0) ? 32'(seenBcd[0]) : 32'hxxxx_xxxx, 32'h8190);
    checkOutput("reconvert second",
                (seenBcd.size() > 1) ? 32'(seenBcd[1]) : 32'hxxxx_xxxx, 32'h8191);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
